// File: rtl/ov7670_stream_tx.sv
// OV7670-style YCbCr 4:2:2 camera stream emulator: PCLK/VSYNC/HREF/DATA with test patterns.
// Optional frame counter enabled by defining OV7670_TX_FRAME_CNT_EN.
module ov7670_stream_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [1:0]  iPATTERN,
  input  logic [7:0]  iLEVEL,
  output logic        oPCLK,
  output logic        oVSYNC,
  output logic        oHREF,
  output logic [7:0]  oDATA,
  output logic        oFRAME_DONE,
  output logic        oBUSY,
  output logic [15:0] oFRAME_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  localparam int          LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] SLOT_LAST  = 16'(LINE_SLOTS - 1);
  localparam logic [15:0] HREF_END   = 16'(2 * H_ACTIVE);
  localparam logic [15:0] X_LAST     = 16'(H_ACTIVE - 1);

  function automatic logic [15:0] last_line(input state_t s);
    logic [15:0] r;
    case (s)
      S_VSYNC:  r = 16'(V_SYNC - 1);
      S_VBACK:  r = 16'(V_BACK - 1);
      S_ACTIVE: r = 16'(V_ACTIVE - 1);
      S_VFRONT: r = 16'(V_FRONT - 1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] luma(input logic [1:0] pat, input logic [7:0] lvl,
                                      input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    case (pat)
      2'd0:    r = x;
      2'd1:    r = y;
      2'd2:    r = (x[5] ^ y[5]) ? 8'd235 : 8'd16;
      default: r = lvl;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic [15:0] slot_q, slot_d;
  logic [15:0] line_q, line_d;
  logic [15:0] x_q, x_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  lvl_q, lvl_d;
  logic        latch;
  logic        line_end;
  logic        href;
  logic        frame_done;

  // All state advances only on the iCLK edge that ends a slot (phase 1 -> 0),
  // so every output is stable across the following oPCLK rising edge.
  always_comb begin
    state_d    = state_q;
    ph_d       = ~ph_q;
    slot_d     = slot_q;
    line_d     = line_q;
    x_d        = x_q;
    pat_d      = pat_q;
    lvl_d      = lvl_q;
    latch      = 1'b0;
    line_end   = (slot_q == SLOT_LAST);
    href       = (state_q == S_ACTIVE) && (slot_q < HREF_END);
    frame_done = ph_q && (state_q == S_VFRONT) && line_end &&
                 (line_q == last_line(S_VFRONT));
    if (ph_q) begin
      if (state_q == S_IDLE) begin
        if (iEN) begin
          state_d = S_VSYNC;
          latch   = 1'b1;
        end
      end else if (line_end) begin
        slot_d = '0;
        x_d    = '0;
        if (line_q == last_line(state_q)) begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            S_VFRONT: begin
              state_d = iEN ? S_VSYNC : S_IDLE;
              latch   = iEN;
            end
            default:  state_d = S_IDLE;
          endcase
        end else begin
          line_d = line_q + 16'd1;
        end
      end else begin
        slot_d = slot_q + 16'd1;
        if (href && slot_q[0]) begin
          x_d = (x_q == X_LAST) ? '0 : x_q + 16'd1;
        end
      end
    end
    if (latch) begin
      pat_d = iPATTERN;
      lvl_d = iLEVEL;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      slot_q  <= '0;
      line_q  <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      slot_q  <= slot_d;
      line_q  <= line_d;
      x_q     <= x_d;
    end
  end

  // Pattern selection is data, only meaningful once a frame has latched it.
  always_ff @(posedge iCLK) begin
    pat_q <= pat_d;
    lvl_q <= lvl_d;
  end

  assign oPCLK       = ph_q;
  assign oVSYNC      = (state_q == S_VSYNC);
  assign oHREF       = href;
  assign oDATA       = !href    ? 8'd0 :
                       slot_q[0] ? luma(pat_q, lvl_q, x_q[7:0], line_q[7:0]) : 8'd128;
  assign oFRAME_DONE = frame_done;
  assign oBUSY       = (state_q != S_IDLE);

`ifdef OV7670_TX_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q + {15'd0, frame_done};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) fcnt_q <= '0;
    else      fcnt_q <= fcnt_d;
  end

  assign oFRAME_CNT = fcnt_q;
`else
  assign oFRAME_CNT = '0;
`endif

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Bench for ov7670_stream_tx: frame-timeline model checked every cycle on two
// instances (H_ACTIVE=4 and H_ACTIVE=64) plus directed literal expectations.
module tb_ov7670_stream_tx;
  localparam int HB = 2, VA = 2, VS = 1, VBK = 1, VF = 1;
`ifdef OV7670_TX_FRAME_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] pat = 2'd0;
  logic [7:0] lvl = 8'd0;

  logic        pclk_o [2];
  logic        vsync_o[2];
  logic        href_o [2];
  logic        done_o [2];
  logic        busy_o [2];
  logic [7:0]  data_o [2];
  logic [15:0] cnt_o  [2];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int q0[$];
  int q1[$];
  int done_n[2] = '{0, 0};

  always #5 clk = ~clk;

  ov7670_stream_tx #(.H_ACTIVE(4), .H_BLANK(HB), .V_ACTIVE(VA), .V_SYNC(VS),
                     .V_BACK(VBK), .V_FRONT(VF)) dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPATTERN(pat), .iLEVEL(lvl),
    .oPCLK(pclk_o[0]), .oVSYNC(vsync_o[0]), .oHREF(href_o[0]), .oDATA(data_o[0]),
    .oFRAME_DONE(done_o[0]), .oBUSY(busy_o[0]), .oFRAME_CNT(cnt_o[0]));

  ov7670_stream_tx #(.H_ACTIVE(64), .H_BLANK(HB), .V_ACTIVE(VA), .V_SYNC(VS),
                     .V_BACK(VBK), .V_FRONT(VF)) dut64 (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPATTERN(pat), .iLEVEL(lvl),
    .oPCLK(pclk_o[1]), .oVSYNC(vsync_o[1]), .oHREF(href_o[1]), .oDATA(data_o[1]),
    .oFRAME_DONE(done_o[1]), .oBUSY(busy_o[1]), .oFRAME_CNT(cnt_o[1]));

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Model: a frame is a flat run of slots; position within it decides everything.
  int m_ph[2]  = '{0, 0};
  int m_t[2]   = '{0, 0};
  int m_pat[2] = '{0, 0};
  int m_lvl[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  bit m_run[2] = '{0, 0};

  function automatic int ha(input int d);
    return (d == 0) ? 4 : 64;
  endfunction
  function automatic int llen(input int d);
    return 2 * ha(d) + HB;
  endfunction
  function automatic int fslots(input int d);
    return llen(d) * (VS + VBK + VA + VF);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ph[d] <= 0; m_run[d] <= 1'b0; m_t[d] <= 0; m_cnt[d] <= 0;
      end else begin
        m_ph[d] <= 1 - m_ph[d];
        if (m_ph[d] == 1) begin
          if (!m_run[d]) begin
            if (en) begin
              m_run[d] <= 1'b1; m_t[d] <= 0; m_pat[d] <= int'(pat); m_lvl[d] <= int'(lvl);
            end
          end else if (m_t[d] == fslots(d) - 1) begin
            m_cnt[d] <= (m_cnt[d] + 1) % 65536;
            m_t[d]   <= 0;
            m_run[d] <= en;
            if (en) begin
              m_pat[d] <= int'(pat); m_lvl[d] <= int'(lvl);
            end
          end else begin
            m_t[d] <= m_t[d] + 1;
          end
        end
      end
    end
  end

  function automatic int e_href(input int d);
    int ln, sl;
    ln = m_t[d] / llen(d);
    sl = m_t[d] % llen(d);
    return int'(m_run[d] && ln >= VS + VBK && ln < VS + VBK + VA && sl < 2 * ha(d));
  endfunction

  function automatic int e_data(input int d);
    int sl, x, y;
    if (e_href(d) == 0) return 0;
    sl = m_t[d] % llen(d);
    if (sl % 2 == 0) return 128;
    x = sl / 2;
    y = m_t[d] / llen(d) - VS - VBK;
    case (m_pat[d])
      0: return x % 256;
      1: return y % 256;
      2: return (((x / 32) + (y / 32)) % 2 == 1) ? 235 : 16;
      default: return m_lvl[d];
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk("pclk", d, int'(pclk_o[d]), m_ph[d]);
        chk("vsync", d, int'(vsync_o[d]), int'(m_run[d] && (m_t[d] / llen(d)) < VS));
        chk("href", d, int'(href_o[d]), e_href(d));
        chk("data", d, int'(data_o[d]), e_data(d));
        chk("done", d, int'(done_o[d]),
            int'(m_run[d] && m_ph[d] == 1 && m_t[d] == fslots(d) - 1));
        chk("busy", d, int'(busy_o[d]), int'(m_run[d]));
        chk("fcnt", d, int'(cnt_o[d]), CNT_ON ? m_cnt[d] : 0);
      end
      if (pclk_o[0] && href_o[0]) q0.push_back(int'(data_o[0]));
      if (pclk_o[1] && href_o[1]) q1.push_back(int'(data_o[1]));
      if (done_o[0]) done_n[0]++;
      if (done_o[1]) done_n[1]++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_q0(input int n, input int budget);
    int k = 0;
    while (q0.size() < n && k < budget) begin step(1); k++; end
    chk("q0_fill", n, int'(q0.size() >= n), 1);
  endtask

  task automatic wait_done(input int d, input int n, input int budget);
    int k = 0;
    while (done_n[d] < n && k < budget) begin step(1); k++; end
    chk("done_wait", d, int'(done_n[d] >= n), 1);
  endtask

  task automatic wait_sig(input int which, input int val, input int budget);
    int k = 0;
    int cur;
    cur = (which == 0) ? int'(href_o[0]) : int'(vsync_o[0]);
    while (cur != val && k < budget) begin
      step(1); k++;
      cur = (which == 0) ? int'(href_o[0]) : int'(vsync_o[0]);
    end
    chk(which == 0 ? "href_wait" : "vsync_wait", val, cur, val);
  endtask

  int exp18[8] = '{128, 0, 128, 1, 128, 2, 128, 3};
  int d0;
  int a;

  initial begin
    @(posedge clk);
    #1 started = 1'b1;
    step(2);
    chk("rst_pclk", 0, int'(pclk_o[0]), 0);
    chk("rst_busy", 0, int'(busy_o[0]), 0);
    chk("rst_vsync", 0, int'(vsync_o[0]), 0);
    chk("rst_cnt", 0, int'(cnt_o[0]), 0);

    rst = 1'b0; en = 1'b1; pat = 2'd0; lvl = 8'h33;
    wait_q0(8, 200);
    for (int i = 0; i < 8; i++) chk("pat0_byte", i, q0[i], exp18[i]);

    step(140);
    pat = 2'd2;
    wait_done(1, 1, 3000);
    pat = 2'd3; lvl = 8'h5A;
    wait_done(1, 2, 3000);
    chk("q64_fill", 0, int'(q1.size() >= 512), 1);
    chk("f1_y_x31", 0, q1[63], 31);
    chk("f1_y_x32", 0, q1[65], 32);
    chk("f2_y_x31", 0, q1[256 + 63], 16);
    chk("f2_y_x32", 0, q1[256 + 65], 235);

    wait_sig(0, 0, 100);
    q0.delete();
    wait_q0(16, 300);
    for (int i = 0; i < 16; i++) chk("pat3_byte", i, q0[i], (i % 2 == 1) ? 8'h5A : 8'h80);

    wait_sig(0, 1, 200);
    en = 1'b0;
    d0 = done_n[0];
    step(300);
    chk("stop_done_cnt", 0, done_n[0] - d0, 1);
    chk("stop_busy", 0, int'(busy_o[0]), 0);
    a = int'(pclk_o[0]);
    step(1);
    chk("idle_pclk_toggle", 0, int'(pclk_o[0]), 1 - a);
    step(1400);
    chk("stop_busy64", 1, int'(busy_o[1]), 0);

    en = 1'b1;
    wait_sig(1, 1, 200);
    wait_sig(1, 0, 200);
    chk("in_vback_busy", 0, int'(busy_o[0]), 1);
    rst = 1'b1;
    d0 = done_n[0];
    step(1);
    chk("mid_rst_pclk", 0, int'(pclk_o[0]), 0);
    chk("mid_rst_vsync", 0, int'(vsync_o[0]), 0);
    chk("mid_rst_href", 0, int'(href_o[0]), 0);
    chk("mid_rst_data", 0, int'(data_o[0]), 0);
    chk("mid_rst_done", 0, int'(done_o[0]), 0);
    chk("mid_rst_busy", 0, int'(busy_o[0]), 0);
    chk("mid_rst_cnt", 0, int'(cnt_o[0]), 0);
    rst = 1'b0;
    step(1);
    chk("mid_rst_no_pulse", 0, done_n[0] - d0, 0);
    wait_done(0, d0 + 3, 1000);
    step(2);
    chk("three_frames_cnt", 0, int'(cnt_o[0]), CNT_ON ? 3 : 0);
    en = 1'b0;
    step(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
